block_checker_pro: RTL and testbench

BLOCK_CHECKER_PRO -- requirements
Module: block_checker_pro

---
 rtl/block_checker_pro_if.sv | 23 ++
 rtl/block_checker_pro.sv | 128 ++++++++++++
 tb/tb_block_checker_pro.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/block_checker_pro_if.sv
// Character-stream handshake and status bundle for block_checker_pro.
// DEPTH_W here must match the DEPTH_W parameter of the checker that uses it.
interface block_checker_pro_if #(
    parameter int DEPTH_W = 8
);
    logic               clr;
    logic               in_valid;
    logic [7:0]         in;
    logic               result;
    logic [DEPTH_W-1:0] depth;
    logic               err_unf;
    logic               err_ovf;

    modport master (
        output clr, in_valid, in,
        input  result, depth, err_unf, err_ovf
    );

    modport slave (
        input  clr, in_valid, in,
        output result, depth, err_unf, err_ovf
    );
endinterface

// File: rtl/block_checker_pro.sv
// Streaming begin/end nesting checker: tracks keywords word by word and commits
// depth changes on each separator, with sticky underflow/overflow flags.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_SEP   | last character was a separator (or reset)
// ST_B..   | prefix of "begin" matched so far
// ST_BEGIN | whole word so far is "begin"
// ST_E..   | prefix of "end" matched so far
// ST_END   | whole word so far is "end"
// ST_OTHER | current word can no longer be a keyword
module block_checker_pro #(
    parameter int DEPTH_W   = 8,
    parameter int CASE_SENS = 0,
    parameter int WS_EXT    = 0
) (
    input  logic                clk,
    input  logic                reset,
    block_checker_pro_if.slave  bus
);

    typedef enum logic [3:0] {
        ST_SEP,
        ST_B,
        ST_BE,
        ST_BEG,
        ST_BEGI,
        ST_BEGIN,
        ST_E,
        ST_EN,
        ST_END,
        ST_OTHER
    } state_t;

    state_t               r_state;
    logic [DEPTH_W-1:0]   r_depth;
    logic                 r_err_unf;
    logic                 r_err_ovf;

    logic [7:0]           w_ch;
    logic                 w_sep;
    state_t               w_next;
    logic                 w_eff_zero;
    logic                 w_depth_full;
    logic                 w_depth_zero;

    // Only A-Z are folded; everything else is compared verbatim.
    always_comb begin
        w_ch = bus.in;
        if (CASE_SENS == 0 && bus.in >= 8'h41 && bus.in <= 8'h5A) begin
            w_ch = bus.in | 8'h20;
        end
    end

    always_comb begin
        w_sep = (bus.in == 8'h20);
        if (WS_EXT != 0 && (bus.in == 8'h09 || bus.in == 8'h0A || bus.in == 8'h0D)) begin
            w_sep = 1'b1;
        end
    end

    always_comb begin
        w_next = ST_OTHER;
        if (w_sep) begin
            w_next = ST_SEP;
        end else begin
            case (r_state)
                ST_SEP:  w_next = (w_ch == "b") ? ST_B : ((w_ch == "e") ? ST_E : ST_OTHER);
                ST_B:    w_next = (w_ch == "e") ? ST_BE    : ST_OTHER;
                ST_BE:   w_next = (w_ch == "g") ? ST_BEG   : ST_OTHER;
                ST_BEG:  w_next = (w_ch == "i") ? ST_BEGI  : ST_OTHER;
                ST_BEGI: w_next = (w_ch == "n") ? ST_BEGIN : ST_OTHER;
                ST_E:    w_next = (w_ch == "n") ? ST_EN    : ST_OTHER;
                ST_EN:   w_next = (w_ch == "d") ? ST_END   : ST_OTHER;
                default: w_next = ST_OTHER;
            endcase
        end
    end

    assign w_depth_full = &r_depth;
    assign w_depth_zero = (r_depth == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_SEP;
            r_depth   <= '0;
            r_err_unf <= 1'b0;
            r_err_ovf <= 1'b0;
        end else if (bus.clr) begin
            r_state   <= ST_SEP;
            r_depth   <= '0;
            r_err_unf <= 1'b0;
            r_err_ovf <= 1'b0;
        end else if (bus.in_valid) begin
            r_state <= w_next;
            if (w_sep) begin
                if (r_state == ST_BEGIN) begin
                    if (w_depth_full) begin
                        r_err_ovf <= 1'b1;
                    end else begin
                        r_depth <= r_depth + DEPTH_W'(1);
                    end
                end else if (r_state == ST_END) begin
                    if (w_depth_zero) begin
                        r_err_unf <= 1'b1;
                    end else begin
                        r_depth <= r_depth - DEPTH_W'(1);
                    end
                end
            end
        end
    end

    // A pending keyword is reflected before its separator commits it.
    always_comb begin
        case (r_state)
            ST_BEGIN: w_eff_zero = 1'b0;
            ST_END:   w_eff_zero = (r_depth == DEPTH_W'(1));
            default:  w_eff_zero = w_depth_zero;
        endcase
    end

    assign bus.result  = !r_err_unf && !r_err_ovf && w_eff_zero;
    assign bus.depth   = r_depth;
    assign bus.err_unf = r_err_unf;
    assign bus.err_ovf = r_err_ovf;

endmodule

// File: tb/tb_block_checker_pro.sv
// Directed bench: four checker instances (defaults, case-sensitive, 2-bit depth,
// extended whitespace) share one character stream; each check targets one instance.
module tb_block_checker_pro;

    logic clk;
    logic reset;

    block_checker_pro_if #(.DEPTH_W(8)) if0 ();
    block_checker_pro_if #(.DEPTH_W(8)) if1 ();
    block_checker_pro_if #(.DEPTH_W(2)) if2 ();
    block_checker_pro_if #(.DEPTH_W(8)) if3 ();

    block_checker_pro #(.DEPTH_W(8), .CASE_SENS(0), .WS_EXT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    block_checker_pro #(.DEPTH_W(8), .CASE_SENS(1), .WS_EXT(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    block_checker_pro #(.DEPTH_W(2), .CASE_SENS(0), .WS_EXT(0)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    block_checker_pro #(.DEPTH_W(8), .CASE_SENS(0), .WS_EXT(1)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] ch;
        logic       vld;
        logic       clr;
        logic       res;
        logic [7:0] dep;
        logic       unf;
        logic       ovf;
        logic [7:0] d1;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [7:0] ch, logic vld, logic clr, logic res,
                                logic [7:0] dep, logic unf, logic ovf, logic [7:0] d1);
        vec_t v;
        v.ch = ch; v.vld = vld; v.clr = clr; v.res = res;
        v.dep = dep; v.unf = unf; v.ovf = ovf; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic v, input logic cl);
        if0.in = c; if0.in_valid = v; if0.clr = cl;
        if1.in = c; if1.in_valid = v; if1.clr = cl;
        if2.in = c; if2.in_valid = v; if2.clr = cl;
        if3.in = c; if3.in_valid = v; if3.clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1, 1'b0);
    endtask

    initial begin
        // "begin end "
        tv.push_back(mk("b", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("e", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("g", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("i", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("n", 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(" ", 1, 0, 0, 1, 0, 0, 1));
        tv.push_back(mk("e", 1, 0, 0, 1, 0, 0, 1));
        tv.push_back(mk("n", 1, 0, 0, 1, 0, 0, 1));
        tv.push_back(mk("d", 1, 0, 1, 1, 0, 0, 1));
        tv.push_back(mk(" ", 1, 0, 1, 0, 0, 0, 0));
        // clr beats a valid 'b'; then "end begin "
        tv.push_back(mk("b", 1, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk("e", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("n", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("d", 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(" ", 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk("b", 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk("e", 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk("g", 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk("i", 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk("n", 1, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(" ", 1, 0, 0, 1, 1, 0, 1));
        // "BeGiN beginx xend EnD " with a 5-cycle invalid gap mid-word
        tv.push_back(mk("x", 1, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk("B", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("e", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("G", 1, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) tv.push_back(mk(" ", 0, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("i", 1, 0, 1, 0, 0, 0, 0));
        tv.push_back(mk("N", 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(" ", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("b", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("e", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("g", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("i", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("n", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("x", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk(" ", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("x", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("e", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("n", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("d", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk(" ", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("E", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("n", 1, 0, 0, 1, 0, 0, 0));
        tv.push_back(mk("D", 1, 0, 1, 1, 0, 0, 0));
        tv.push_back(mk(" ", 1, 0, 1, 0, 0, 0, 0));

        reset = 1'b1;
        if0.in = 8'h00; if0.in_valid = 1'b0; if0.clr = 1'b0;
        if1.in = 8'h00; if1.in_valid = 1'b0; if1.clr = 1'b0;
        if2.in = 8'h00; if2.in_valid = 1'b0; if2.clr = 1'b0;
        if3.in = 8'h00; if3.in_valid = 1'b0; if3.clr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_result", 32'(if0.result), 32'd1);
        chk("reset_depth", 32'(if0.depth), 32'd0);
        chk("reset_unf", 32'(if0.err_unf), 32'd0);
        chk("reset_ovf", 32'(if0.err_ovf), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].ch, tv[i].vld, tv[i].clr);
            chk($sformatf("vec%0d_result", i), 32'(if0.result), 32'(tv[i].res));
            chk($sformatf("vec%0d_depth", i), 32'(if0.depth), 32'(tv[i].dep));
            chk($sformatf("vec%0d_unf", i), 32'(if0.err_unf), 32'(tv[i].unf));
            chk($sformatf("vec%0d_ovf", i), 32'(if0.err_ovf), 32'(tv[i].ovf));
            chk($sformatf("vec%0d_cs_depth", i), 32'(if1.depth), 32'(tv[i].d1));
        end

        // 2-bit depth saturation
        drive(8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            send_str("begin ");
            chk($sformatf("sat%0d_depth", k), 32'(if2.depth), (k < 3) ? 32'(k) : 32'd3);
            chk($sformatf("sat%0d_ovf", k), 32'(if2.err_ovf), (k == 4) ? 32'd1 : 32'd0);
        end
        send_str("end ");
        chk("sat_end_depth", 32'(if2.depth), 32'd2);
        chk("sat_end_result", 32'(if2.result), 32'd0);
        chk("sat_end_ovf", 32'(if2.err_ovf), 32'd1);

        // extended whitespace
        drive(8'h00, 1'b0, 1'b1);
        send_str("begin\t");
        chk("ws_tab_depth", 32'(if3.depth), 32'd1);
        chk("ws_tab_result", 32'(if3.result), 32'd0);
        chk("ws_tab_plain_result", 32'(if0.result), 32'd1);
        send_str("end\n");
        chk("ws_nl_depth", 32'(if3.depth), 32'd0);
        chk("ws_nl_result", 32'(if3.result), 32'd1);
        chk("ws_nl_plain_depth", 32'(if0.depth), 32'd0);

        // asynchronous reset mid-keyword
        drive(8'h00, 1'b0, 1'b1);
        send_str("begin begin begi");
        chk("async_pre_depth", 32'(if0.depth), 32'd2);
        chk("async_pre_result", 32'(if0.result), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_depth", 32'(if0.depth), 32'd0);
        chk("async_result", 32'(if0.result), 32'd1);
        #1 reset = 1'b0;
        send_str("end ");
        chk("async_end_unf", 32'(if0.err_unf), 32'd1);
        chk("async_end_depth", 32'(if0.depth), 32'd0);
        chk("async_end_result", 32'(if0.result), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
